adc_capture_buffer: RTL and testbench
=====================================

ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 Parameter PRECISION, default 10, ADC code width per channel (1..13).
REQ-002 Parameter NUM_CH, default 2, ADC channel count (1..8).
REQ-003 Parameter ADDR_W, default 10, buffer depth DEPTH = 2^ADDR_W frames (one frame = one sample of every channel).
REQ-004 Port clk  in  1  single clock for capture and readback; all logic on rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port sample_valid  in  1  frame strobe, one cycle per ADC conversion.
REQ-007 Port sample_data  in  NUM_CH*PRECISION  frame; channel k at bits [k*PRECISION +: PRECISION].
REQ-008 Port mode  in  2  0 free-run, 1 single-shot, 2 threshold trigger, 3 reserved (treated as 1); sampled on arm.
REQ-009 Port arm  in  1  start-capture pulse.
REQ-010 Port abort  in  1  return to IDLE, buffer contents kept.
REQ-011 Port trig_ch  in  3  trigger channel index (mode 2).
REQ-012 Port trig_level  in  PRECISION  rising-edge threshold (mode 2).
REQ-013 Port capture_len  in  ADDR_W+1  frames to store (modes 1/2); sampled on arm.
REQ-014 Port rd_en  in  1  host pipe read strobe, one word per cycle.
REQ-015 Port rd_data  out  16  {channel[15:13], zero pad, code[PRECISION-1:0]}.
REQ-016 Port rd_valid  out  1  rd_data holds a valid word.
REQ-017 Port frame_count  out  ADDR_W+1  frames stored and not fully read.
REQ-018 Port state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
REQ-019 Port overflow / underflow  out  1 each  sticky error flags.

Function
REQ-020 arm in any state SHALL clear pointers, frame_count, flags and read channel index; enter CAPTURE (modes 0,1,3) or ARMED (mode 2) next cycle.
REQ-021 abort SHALL force IDLE next cycle; abort and arm in same cycle: abort wins.
REQ-022 ARMED: trigger when prev_code < trig_level and cur_code >= trig_level on trig_ch, both from valid frames; the triggering frame SHALL be the first stored; prev_code resets to all-ones on arm (no trigger on first frame); trig_ch >= NUM_CH never triggers.
REQ-023 CAPTURE SHALL write each valid frame; mode 1/2: after capture_len frames go to DONE on the cycle after the last write.
REQ-024 capture_len = 0 or > DEPTH SHALL be treated as DEPTH.
REQ-025 Mode 0 SHALL stay in CAPTURE until abort or arm; buffer acts as circular FIFO.
REQ-026 Write when frame_count = DEPTH SHALL be dropped and set overflow, unless a frame pop occurs same cycle (then accepted).
REQ-027 Readback allowed in every state; each rd_en with frame_count > 0 emits the current frame's channel at read index, index increments mod NUM_CH.
REQ-028 Frame pop (read pointer +1, frame_count -1) SHALL occur on read of channel NUM_CH-1.
REQ-029 rd_data/rd_valid SHALL update exactly 1 cycle after rd_en.
REQ-030 rd_en with frame_count = 0 SHALL give rd_data = 0, rd_valid = 0, set underflow.
REQ-031 Simultaneous write and pop SHALL leave frame_count unchanged; pointers wrap modulo DEPTH.
REQ-032 Flags clear only on arm or reset.

Reset
REQ-033 rst_n low SHALL immediately set state IDLE, pointers, frame_count, read index, rd_data, rd_valid, overflow, underflow to 0; RAM contents are not reset.
REQ-034 Reset mid-capture discards all stored frames; first activity after release requires arm.

Structure
REQ-035 Package adc_capture_pkg SHALL hold mode and state encodings and CH_TAG_W = 3.
REQ-036 One sub-module adc_frame_ram: simple dual-port, width NUM_CH*PRECISION, depth DEPTH, synchronous 1-cycle read.

Verification (PRECISION=10, NUM_CH=2, ADDR_W=4)
REQ-037 Mode 1, capture_len=3, frames {0x001,0x002},{0x003,0x004},{0x005,0x006}, 6 rd_en -> words 0x0001,0x2002,0x0003,0x2004,0x0005,0x2006; state DONE; frame_count 0.
REQ-038 Mode 2, trig_ch=1, trig_level=0x200, ch1 sequence 0x100,0x1FF,0x200,0x300, capture_len=2 -> stored frames are those with ch1=0x200 and 0x300.
REQ-039 Mode 0, 17 frames with no reads -> frame_count 16, overflow=1, 17th frame absent from readback.
REQ-040 rd_en at frame_count 0 -> rd_valid=0, rd_data=0x0000, underflow=1; next arm clears it.
REQ-041 rst_n low during CAPTURE after 5 frames -> state IDLE, frame_count 0, rd_valid 0 immediately, without clk edge.
REQ-042 Mode 0 at frame_count 16, write coincident with ch1 read -> write accepted, frame_count stays 16, overflow stays 0.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared encodings for the ADC capture buffer: capture modes, FSM states
// and the channel tag width used in readback words.
package adc_capture_pkg;

    localparam int unsigned CH_TAG_W = 3;

    typedef enum logic [1:0] {
        ModeFree   = 2'd0,
        ModeSingle = 2'd1,
        ModeTrig   = 2'd2,
        ModeRsvd   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

endpackage

// File: rtl/adc_frame_ram.sv
// Simple dual-port frame store with a registered (1-cycle) read port.
// A write to the address being read is forwarded so the read never returns stale data.
module adc_frame_ram #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC frame capture buffer with free-run, single-shot and
// threshold-trigger modes, drained one channel word per cycle by a host pipe.
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int unsigned PRECISION = 10,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_valid,
    input  logic [NUM_CH*PRECISION-1:0] sample_data,
    input  logic [1:0]                  mode,
    input  logic                        arm,
    input  logic                        abort,
    input  logic [2:0]                  trig_ch,
    input  logic [PRECISION-1:0]        trig_level,
    input  logic [ADDR_W:0]             capture_len,
    input  logic                        rd_en,
    output logic [15:0]                 rd_data,
    output logic                        rd_valid,
    output logic [ADDR_W:0]             frame_count,
    output logic [1:0]                  state,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned FRAME_W = NUM_CH * PRECISION;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CH_TAG_W-1:0] LAST_CH   = CH_TAG_W'(NUM_CH - 1);

    state_e                state_q;
    mode_e                 mode_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      stored_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic [ADDR_W-1:0]     rd_ptr_d;
    logic [CH_TAG_W-1:0]   rd_ch_q;
    logic [PRECISION-1:0]  prev_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic [15:0]           rd_data_q;
    logic                  rd_valid_q;
    logic [FRAME_W-1:0]    ram_rdata;

    logic                  arm_go;
    logic                  trig_ok;
    logic                  trig_hit;
    logic [PRECISION-1:0]  trig_code;
    logic                  wr_req;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  pop;
    logic                  full;
    logic                  last_write;
    logic [CNT_W-1:0]      len_norm;
    logic [15:0]           rd_word;

    function automatic logic [PRECISION-1:0] chan_code(input logic [FRAME_W-1:0]  frame,
                                                       input logic [CH_TAG_W-1:0] ch);
        chan_code = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_TAG_W'(k)) begin
                chan_code = frame[k*PRECISION +: PRECISION];
            end
        end
    endfunction

    always_comb begin
        arm_go    = arm && !abort;
        trig_code = chan_code(sample_data, trig_ch);
        trig_ok   = ({1'b0, trig_ch} < 4'(NUM_CH));
        trig_hit  = sample_valid && trig_ok && (prev_q < trig_level) && (trig_code >= trig_level);

        // No writes while the FSM is being redirected by arm or abort.
        wr_req = sample_valid && !arm && !abort &&
                 ((state_q == StCapture) || ((state_q == StArmed) && trig_hit));
        full   = (count_q == DEPTH_CNT);
        rd_ok  = rd_en && (count_q != '0);
        pop    = rd_ok && (rd_ch_q == LAST_CH) && !arm_go;
        wr_ok  = wr_req && (!full || pop);

        last_write = wr_ok && (mode_q != ModeFree) && ((stored_q + CNT_W'(1)) == len_q);

        len_norm = ((capture_len == '0) || (capture_len > DEPTH_CNT)) ? DEPTH_CNT : capture_len;

        if (arm_go) begin
            rd_ptr_d = '0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        rd_word                  = '0;
        rd_word[15 -: CH_TAG_W]  = rd_ch_q;
        rd_word[PRECISION-1:0]   = chan_code(ram_rdata, rd_ch_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= ModeFree;
            len_q      <= DEPTH_CNT;
            stored_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_ch_q    <= '0;
            prev_q     <= '1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (abort) begin
                state_q <= StIdle;
            end else if (arm) begin
                state_q <= (mode == ModeTrig) ? StArmed : StCapture;
            end else begin
                unique case (state_q)
                    StArmed:   if (wr_ok) state_q <= last_write ? StDone : StCapture;
                    StCapture: if (last_write) state_q <= StDone;
                    default:   ;
                endcase
            end

            if (arm_go) begin
                mode_q   <= mode_e'(mode);
                len_q    <= len_norm;
                stored_q <= '0;
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ch_q  <= '0;
                prev_q   <= '1;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
            end else begin
                if (sample_valid) prev_q <= trig_code;
                if (wr_ok) begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    stored_q <= stored_q + CNT_W'(1);
                end
                if (wr_req && full && !pop) ovf_q <= 1'b1;
                if (wr_ok && !pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (pop && !wr_ok) begin
                    count_q <= count_q - CNT_W'(1);
                end
                if (rd_ok) begin
                    rd_ch_q <= (rd_ch_q == LAST_CH) ? '0 : rd_ch_q + CH_TAG_W'(1);
                end else if (rd_en) begin
                    udf_q <= 1'b1;
                end
            end

            rd_ptr_q <= rd_ptr_d;

            if (rd_en) begin
                rd_data_q  <= rd_ok ? rd_word : 16'h0000;
                rd_valid_q <= rd_ok;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // Read port tracks the next read pointer so the current frame is always ready.
    adc_frame_ram #(
        .WIDTH  (FRAME_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (sample_data),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign frame_count = count_q;
    assign state       = state_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer (PRECISION=10, NUM_CH=2, ADDR_W=4).
module tb_adc_capture_buffer;

    localparam int unsigned P = 10;
    localparam int unsigned N = 2;
    localparam int unsigned A = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sample_valid = 1'b0;
    logic [N*P-1:0] sample_data = '0;
    logic [1:0]     mode = 2'd0;
    logic           arm = 1'b0;
    logic           abort = 1'b0;
    logic [2:0]     trig_ch = 3'd0;
    logic [P-1:0]   trig_level = '0;
    logic [A:0]     capture_len = '0;
    logic           rd_en = 1'b0;
    logic [15:0]    rd_data;
    logic           rd_valid;
    logic [A:0]     frame_count;
    logic [1:0]     state;
    logic           overflow;
    logic           underflow;

    int n_cmp = 0;
    int n_err = 0;

    adc_capture_buffer #(
        .PRECISION (P),
        .NUM_CH    (N),
        .ADDR_W    (A)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .mode         (mode),
        .arm          (arm),
        .abort        (abort),
        .trig_ch      (trig_ch),
        .trig_level   (trig_level),
        .capture_len  (capture_len),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .frame_count  (frame_count),
        .state        (state),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cfg(input logic [1:0] m, input logic [A:0] len);
        mode        = m;
        capture_len = len;
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
    endtask

    task automatic push(input logic [P-1:0] c0, input logic [P-1:0] c1);
        sample_valid = 1'b1;
        sample_data  = {c1, c0};
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic rd_empty(input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_data"}, 32'(rd_data), 32'h0);
        chk({tag, "_vld"}, 32'(rd_valid), 32'd0);
        chk({tag, "_udf"}, 32'(underflow), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("rst_vld", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Underflow on empty buffer, cleared by arm
        rd_empty("udf0");

        // Single-shot capture of three frames, then full readback
        arm_cfg(2'd1, 5'd3);
        chk("ss_udf_clr", 32'(underflow), 32'd0);
        chk("ss_state_cap", 32'(state), 32'd2);
        push(10'h001, 10'h002);
        push(10'h003, 10'h004);
        chk("ss_state_mid", 32'(state), 32'd2);
        push(10'h005, 10'h006);
        chk("ss_state_done", 32'(state), 32'd3);
        chk("ss_count3", 32'(frame_count), 32'd3);
        push(10'h007, 10'h008);
        chk("ss_count_hold", 32'(frame_count), 32'd3);
        rd_chk("ss_w0", 16'h0001);
        rd_chk("ss_w1", 16'h2002);
        rd_chk("ss_w2", 16'h0003);
        rd_chk("ss_w3", 16'h2004);
        rd_chk("ss_w4", 16'h0005);
        rd_chk("ss_w5", 16'h2006);
        chk("ss_state_end", 32'(state), 32'd3);
        chk("ss_count0", 32'(frame_count), 32'd0);

        // Abort keeps contents; abort beats a simultaneous arm
        arm_cfg(2'd1, 5'd3);
        push(10'h0AB, 10'h0CD);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_state", 32'(state), 32'd0);
        chk("ab_count", 32'(frame_count), 32'd1);
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        chk("ab_arm_state", 32'(state), 32'd0);
        chk("ab_arm_count", 32'(frame_count), 32'd1);

        // Trigger channel outside NUM_CH never fires
        trig_ch    = 3'd5;
        trig_level = 10'h200;
        arm_cfg(2'd2, 5'd2);
        chk("tbad_armed", 32'(state), 32'd1);
        push(10'h100, 10'h100);
        push(10'h300, 10'h300);
        chk("tbad_state", 32'(state), 32'd1);
        chk("tbad_count", 32'(frame_count), 32'd0);

        // Threshold trigger on ch1, rising through 0x200
        trig_ch = 3'd1;
        arm_cfg(2'd2, 5'd2);
        chk("trg_armed", 32'(state), 32'd1);
        push(10'h011, 10'h100);
        push(10'h022, 10'h1FF);
        chk("trg_wait", 32'(state), 32'd1);
        chk("trg_wait_cnt", 32'(frame_count), 32'd0);
        push(10'h033, 10'h200);
        chk("trg_cap", 32'(state), 32'd2);
        chk("trg_cnt1", 32'(frame_count), 32'd1);
        push(10'h044, 10'h300);
        chk("trg_done", 32'(state), 32'd3);
        push(10'h055, 10'h3FF);
        chk("trg_cnt2", 32'(frame_count), 32'd2);
        rd_chk("trg_w0", 16'h0033);
        rd_chk("trg_w1", 16'h2200);
        rd_chk("trg_w2", 16'h0044);
        rd_chk("trg_w3", 16'h2300);

        // Free-run overflow: 17th frame is dropped
        arm_cfg(2'd0, 5'd0);
        for (int i = 1; i <= 17; i++) push(10'(i), 10'(32'h100 + i));
        chk("ovf_count", 32'(frame_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_state", 32'(state), 32'd2);
        for (int i = 1; i <= 16; i++) begin
            rd_chk($sformatf("ovf_f%0d_c0", i), 16'(i));
            rd_chk($sformatf("ovf_f%0d_c1", i), 16'(32'h2100 + i));
        end
        rd_empty("ovf_no17");

        // Full buffer: write coinciding with the popping ch1 read is accepted
        arm_cfg(2'd0, 5'd0);
        for (int i = 1; i <= 16; i++) push(10'(32'h10 + i), 10'(32'h200 + i));
        chk("fp_count", 32'(frame_count), 32'd16);
        chk("fp_ovf0", 32'(overflow), 32'd0);
        rd_chk("fp_f1_c0", 16'h0011);
        rd_en        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = {10'h3BB, 10'h0AA};
        tick();
        rd_en        = 1'b0;
        sample_valid = 1'b0;
        chk("fp_f1_c1", 32'(rd_data), 32'h2201);
        chk("fp_count_hold", 32'(frame_count), 32'd16);
        chk("fp_ovf_hold", 32'(overflow), 32'd0);
        for (int i = 2; i <= 16; i++) begin
            rd_chk($sformatf("fp_f%0d_c0", i), 16'(32'h0010 + i));
            rd_chk($sformatf("fp_f%0d_c1", i), 16'(32'h2200 + i));
        end
        rd_chk("fp_new_c0", 16'h00AA);
        rd_chk("fp_new_c1", 16'h23BB);
        chk("fp_count0", 32'(frame_count), 32'd0);

        // Asynchronous reset mid-capture
        arm_cfg(2'd0, 5'd0);
        for (int i = 1; i <= 5; i++) push(10'(i), 10'(i));
        chk("ar_count5", 32'(frame_count), 32'd5);
        rd_chk("ar_pre", 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_count", 32'(frame_count), 32'd0);
        chk("ar_vld", 32'(rd_valid), 32'd0);
        chk("ar_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(10'h111, 10'h222);
        chk("ar_idle", 32'(state), 32'd0);
        chk("ar_nostore", 32'(frame_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
